// File: rtl/puc_pkg.sv
// Shared PUC CPU definitions: boot-loader framing constants, loader states and opcode encodings.
package puc_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LENGTH  = 3'd1,
        DATA_LO = 3'd2,
        DATA_HI = 3'd3,
        WRITE   = 3'd4,
        CHECK   = 3'd5,
        RUN     = 3'd6,
        ERROR   = 3'd7
    } loader_state_t;

    // Opcode encodings; RESET is what the external hold mux forces while holdCpu is high.
    localparam logic [3:0] OP_RESET = 4'h0;
    localparam logic [3:0] OP_NOP   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JUMP  = 4'h5;
    localparam logic [3:0] OP_JZ    = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;

endpackage

// File: rtl/program_loader.sv
// Boot-time loader: parses a framed byte stream into program-memory writes, verifies the XOR
// checksum and holds the CPU in RESET until a good image is present.
module program_loader
    import puc_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int VALUE_WIDTH  = 8,
    parameter int PC_WIDTH     = 8,
    parameter int WORD_WIDTH   = OPCODE_WIDTH + VALUE_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  startLoad,
    input  logic [7:0]            rxData,
    input  logic                  rxValid,
    output logic                  rxReady,
    output logic                  memWriteEnable,
    output logic [PC_WIDTH-1:0]   memWriteAddress,
    output logic [WORD_WIDTH-1:0] memWriteData,
    output logic                  holdCpu,
    output logic                  loaded,
    output logic                  checksumError,
    output logic [PC_WIDTH:0]     wordCount
);

    loader_state_t         r_state;
    loader_state_t         w_state_next;
    logic [7:0]            r_remaining;
    logic [7:0]            r_lo;
    logic [7:0]            r_xor;
    logic [PC_WIDTH-1:0]   r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [PC_WIDTH:0]     r_wcount;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_sync;
    logic                  w_enter_length;

    assign rxReady        = (r_state != WRITE);
    assign w_accept       = rxValid && rxReady;
    assign w_sync         = w_accept && (rxData == SYNC_BYTE);
    assign w_enter_length = !startLoad && w_sync && (r_state == IDLE || r_state == ERROR);

    always_comb begin
        w_state_next = r_state;
        if (startLoad) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (w_sync) w_state_next = LENGTH;
                LENGTH:  if (w_accept) w_state_next = DATA_LO;
                DATA_LO: if (w_accept) w_state_next = DATA_HI;
                DATA_HI: if (w_accept) w_state_next = WRITE;
                // r_remaining counts words still to write after the current one
                WRITE:   w_state_next = (r_remaining == 8'd0) ? CHECK : DATA_LO;
                CHECK:   if (w_accept) w_state_next = (rxData == r_xor) ? RUN : ERROR;
                RUN:     w_state_next = RUN;
                ERROR:   if (w_sync) w_state_next = LENGTH;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_remaining <= 8'd0;
            r_lo        <= 8'd0;
            r_xor       <= 8'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wcount    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (startLoad || w_enter_length) begin
                r_addr   <= '0;
                r_wcount <= '0;
                r_xor    <= 8'd0;
                r_err    <= 1'b0;
            end else begin
                unique case (r_state)
                    LENGTH: if (w_accept) r_remaining <= rxData;
                    DATA_LO: begin
                        if (w_accept) begin
                            r_lo  <= rxData;
                            r_xor <= r_xor ^ rxData;
                        end
                    end
                    DATA_HI: begin
                        if (w_accept) begin
                            r_wdata <= WORD_WIDTH'({rxData, r_lo});
                            r_xor   <= r_xor ^ rxData;
                        end
                    end
                    WRITE: begin
                        r_addr      <= r_addr + 1'b1;
                        r_wcount    <= r_wcount + 1'b1;
                        r_remaining <= r_remaining - 8'd1;
                    end
                    CHECK: if (w_accept && rxData != r_xor) r_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign memWriteEnable  = (r_state == WRITE);
    assign memWriteAddress = r_addr;
    assign memWriteData    = r_wdata;
    assign holdCpu         = (r_state != RUN);
    assign loaded          = (r_state == RUN);
    assign checksumError   = r_err;
    assign wordCount       = r_wcount;

endmodule
